// File: rtl/y86_regfile_sb_if.sv
// Register-file bus: two read ports, E/M write ports, load scoreboard and debug read.
// master = pipeline/controller side, slave = register file.
interface y86_regfile_sb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              wE_en;
  logic [ADDR_W-1:0] dstE;
  logic [DATA_W-1:0] valE;
  logic              wM_en;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valM;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dst;
  logic              busyA;
  logic              busyB;
  logic [ADDR_W-1:0] dbg_idx;
  logic [DATA_W-1:0] dbg_val;

  modport master (
    output srcA, srcB, wE_en, dstE, valE, wM_en, dstM, valM,
           issue_en, issue_dst, dbg_idx,
    input  valA, valB, busyA, busyB, dbg_val
  );

  modport slave (
    input  srcA, srcB, wE_en, dstE, valE, wM_en, dstM, valM,
           issue_en, issue_dst, dbg_idx,
    output valA, valB, busyA, busyB, dbg_val
  );
endinterface

// File: rtl/y86_regfile_sb.sv
// Y86 register file (2R/2W) with a per-register pending-load busy vector.
// Define REGFILE_BYPASS_EN to forward same-cycle M/E writes to valA/valB and busyA/busyB.
module y86_regfile_sb #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 15,
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RNONE    = {ADDR_W{1'b1}},
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input logic               clock,
  input logic               reset,
  y86_regfile_sb_if.slave   rf
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;

  function automatic logic idx_ok(input logic [ADDR_W-1:0] i);
    return (i != RNONE) && (int'(i) < NREGS);
  endfunction

  logic we_e, we_m, set_b;
  assign we_e  = rf.wE_en    && idx_ok(rf.dstE);
  assign we_m  = rf.wM_en    && idx_ok(rf.dstM);
  assign set_b = rf.issue_en && idx_ok(rf.issue_dst);

  // M applied after E so valM wins on a shared destination; issue applied after
  // the M-port clear so a fresh load stays marked busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we_e) regs_d[rf.dstE] = rf.valE;
    if (we_m) begin
      regs_d[rf.dstM] = rf.valM;
      busy_d[rf.dstM] = 1'b0;
    end
    if (set_b) busy_d[rf.issue_dst] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q          <= '0;
      regs_q[RSP_IDX] <= RSP_INIT;
      busy_q          <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_idx;
  logic [1:0][DATA_W-1:0] rd_val;
  logic [1:0]             rd_busy;

  assign rd_idx = {rf.srcB, rf.srcA};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic ok;
    assign ok = idx_ok(rd_idx[p]);
`ifdef REGFILE_BYPASS_EN
    logic m_hit, e_hit, re_set;
    assign m_hit  = we_m  && (rf.dstM      == rd_idx[p]);
    assign e_hit  = we_e  && (rf.dstE      == rd_idx[p]);
    assign re_set = set_b && (rf.issue_dst == rd_idx[p]);
    assign rd_val[p]  = !ok   ? '0      :
                        m_hit ? rf.valM :
                        e_hit ? rf.valE : regs_q[rd_idx[p]];
    // The returning load releases the consumer now unless another load re-claims it.
    assign rd_busy[p] = ok && busy_q[rd_idx[p]] && !(m_hit && !re_set);
`else
    assign rd_val[p]  = ok ? regs_q[rd_idx[p]] : '0;
    assign rd_busy[p] = ok && busy_q[rd_idx[p]];
`endif
  end

  assign rf.valA    = rd_val[0];
  assign rf.valB    = rd_val[1];
  assign rf.busyA   = rd_busy[0];
  assign rf.busyB   = rd_busy[1];
  assign rf.dbg_val = idx_ok(rf.dbg_idx) ? regs_q[rf.dbg_idx] : '0;

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Bench for y86_regfile_sb: directed literal checks plus randomized traffic
// compared every cycle against an array-based model of the register file.
module tb_y86_regfile_sb;
  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_F000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  y86_regfile_sb_if #(.DATA_W(64), .ADDR_W(4)) rf ();

  y86_regfile_sb #(.RSP_INIT(RSP_INIT)) dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // model state: architectural registers and outstanding-load flags
  logic [63:0] m_reg  [15];
  bit          m_busy [15];

  function automatic bit ok(input logic [3:0] i);
    return i < 4'd15;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] exp_val(input logic [3:0] s);
    if (!ok(s)) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (rf.wM_en && rf.dstM == s) return rf.valM;
    if (rf.wE_en && rf.dstE == s) return rf.valE;
`endif
    return m_reg[s];
  endfunction

  function automatic bit exp_busy(input logic [3:0] s);
    if (!ok(s)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rf.wM_en && rf.dstM == s && !(rf.issue_en && rf.issue_dst == s)) return 1'b0;
`endif
    return m_busy[s];
  endfunction

  // model update on each rising edge
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        m_reg[i]  = 64'd0;
        m_busy[i] = 1'b0;
      end
      m_reg[4] = RSP_INIT;
    end else begin
      if (rf.wE_en && ok(rf.dstE)) m_reg[rf.dstE] = rf.valE;
      if (rf.wM_en && ok(rf.dstM)) begin
        m_reg[rf.dstM]  = rf.valM;
        m_busy[rf.dstM] = 1'b0;
      end
      if (rf.issue_en && ok(rf.issue_dst)) m_busy[rf.issue_dst] = 1'b1;
    end
  end

  // compare process: outputs are meaningful every cycle once reset has run
  always @(negedge clock) begin
    if (chk_en) begin
      chk("valA",    rf.valA,    exp_val(rf.srcA));
      chk("valB",    rf.valB,    exp_val(rf.srcB));
      chk("busyA",   64'(rf.busyA), 64'(exp_busy(rf.srcA)));
      chk("busyB",   64'(rf.busyB), 64'(exp_busy(rf.srcB)));
      chk("dbg_val", rf.dbg_val, ok(rf.dbg_idx) ? m_reg[rf.dbg_idx] : 64'd0);
    end
  end

  task automatic idle();
    rf.srcA = 4'hF; rf.srcB = 4'hF; rf.dbg_idx = 4'hF;
    rf.wE_en = 0; rf.dstE = 4'hF; rf.valE = '0;
    rf.wM_en = 0; rf.dstM = 4'hF; rf.valM = '0;
    rf.issue_en = 0; rf.issue_dst = 4'hF;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: reset state
    rf.srcA = 4'd0; rf.srcB = 4'd4;
    @(negedge clock);
    chk("t1_valA_r0", rf.valA, 64'd0);
    chk("t1_valB_rsp", rf.valB, 64'h0000_0000_0000_F000);
    chk("t1_busy", {62'd0, rf.busyA, rf.busyB}, 64'd0);
    step();

    // 2: E-port write, RNONE read
    rf.wE_en = 1; rf.dstE = 4'd3; rf.valE = 64'h1234; rf.srcA = 4'd3; rf.srcB = 4'hF;
    step();
    idle(); rf.srcA = 4'd3; rf.srcB = 4'hF;
    @(negedge clock);
    chk("t2_valA", rf.valA, 64'h1234);
    chk("t2_valB_rnone", rf.valB, 64'd0);
    step();

    // 3: E and M to the same register, M wins
    rf.wE_en = 1; rf.dstE = 4'd4; rf.valE = 64'd5;
    rf.wM_en = 1; rf.dstM = 4'd4; rf.valM = 64'd9;
    step();
    idle(); rf.srcA = 4'd4; rf.dbg_idx = 4'd4;
    @(negedge clock);
    chk("t3_valA", rf.valA, 64'd9);
    chk("t3_dbg", rf.dbg_val, 64'd9);
    step();

    // 4: load-use busy then release by M write
    rf.issue_en = 1; rf.issue_dst = 4'd2; rf.srcA = 4'd2;
    @(negedge clock);
    chk("t4_busy_before", 64'(rf.busyA), 64'd0);
    step();
    idle(); rf.srcA = 4'd2;
    @(negedge clock);
    chk("t4_busy_set", 64'(rf.busyA), 64'd1);
    step();
    rf.wM_en = 1; rf.dstM = 4'd2; rf.valM = 64'h77;
    @(negedge clock);
`ifdef REGFILE_BYPASS_EN
    chk("t4_byp_valA", rf.valA, 64'h77);
    chk("t4_byp_busyA", 64'(rf.busyA), 64'd0);
`else
    chk("t4_nb_valA", rf.valA, 64'd0);
    chk("t4_nb_busyA", 64'(rf.busyA), 64'd1);
`endif
    step();
    idle(); rf.srcA = 4'd2;
    @(negedge clock);
    chk("t4_valA_after", rf.valA, 64'h77);
    chk("t4_busy_after", 64'(rf.busyA), 64'd0);
    step();

    // 5: issue and M clear on same register in one cycle, set wins
    rf.issue_en = 1; rf.issue_dst = 4'd2; rf.wM_en = 1; rf.dstM = 4'd2; rf.valM = 64'h55;
    step();
    idle(); rf.srcA = 4'd2;
    @(negedge clock);
    chk("t5_busy_kept", 64'(rf.busyA), 64'd1);
    chk("t5_valA", rf.valA, 64'h55);
    step();
    rf.wM_en = 1; rf.dstM = 4'd2; rf.valM = 64'h55;
    step();

    // 6: reset overrides writes and issues, clears busy
    idle(); rf.issue_en = 1; rf.issue_dst = 4'd5; rf.wE_en = 1; rf.dstE = 4'd7; rf.valE = 64'hAA;
    step();
    idle(); rf.srcA = 4'd5; rf.dbg_idx = 4'd7;
    @(negedge clock);
    chk("t6_busy5", 64'(rf.busyA), 64'd1);
    chk("t6_dbg7", rf.dbg_val, 64'hAA);
    step();
    reset = 1; rf.wE_en = 1; rf.dstE = 4'd7; rf.valE = 64'hBB;
    rf.issue_en = 1; rf.issue_dst = 4'd6;
    step();
    reset = 0; idle(); rf.srcA = 4'd5; rf.srcB = 4'd6; rf.dbg_idx = 4'd7;
    @(negedge clock);
    chk("t6_reg7_cleared", rf.dbg_val, 64'd0);
    chk("t6_busy_cleared", {62'd0, rf.busyA, rf.busyB}, 64'd0);
    step();

    // randomized traffic, biased toward overlapping indices
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      rf.srcA      = 4'($urandom_range(0, 15));
      rf.srcB      = 4'($urandom_range(0, 15));
      rf.dbg_idx   = 4'($urandom_range(0, 15));
      rf.wE_en     = 1'($urandom_range(0, 1));
      rf.dstE      = 4'($urandom_range(0, 15));
      rf.valE      = {$urandom, $urandom};
      rf.wM_en     = 1'($urandom_range(0, 1));
      rf.dstM      = ($urandom_range(0, 3) == 0) ? rf.dstE : 4'($urandom_range(0, 15));
      rf.valM      = {$urandom, $urandom};
      rf.issue_en  = 1'($urandom_range(0, 1));
      rf.issue_dst = ($urandom_range(0, 3) == 0) ? rf.srcA : 4'($urandom_range(0, 15));
      step();
    end
    reset = 0;
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
